tw_cmult_st4: RTL and testbench

- Reader side of the stage-4 twiddle ROM interface, placed between the stage-4 butterfly output and the stage-5 input.
- Tracks the sample index of the incoming stream and drives the ROM's addr/valid pins.
- Aligns each data sample with the 1-cycle-late registered twiddle, then multiplies them (Q1.11 twiddle) with rounding and saturation.
- Streaming only, no backpressure.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/cmult_pipe.sv | 102 ++++++++++
 rtl/tw_cmult_st4.sv | 113 +++++++++++
 tb/tb_tw_cmult_st4.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
//   DEF_DATA_W / DEF_TW_W : default sample and twiddle widths
//   cplx_t / tw_t         : packed complex sample and twiddle types
//   sat_rnd()             : round-half-up right shift followed by signed saturation
package fft_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_TW_W   = 12;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [DEF_TW_W-1:0] re;
    logic signed [DEF_TW_W-1:0] im;
  } tw_t;

  // Adds 2^(shift-1), arithmetic-shifts right by shift, then clamps to the
  // signed range of 'width' bits. shift must be >= 1, width <= 63.
  function automatic logic signed [63:0] sat_rnd(input logic signed [63:0] value,
                                                 input int unsigned shift,
                                                 input int unsigned width);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (r > max_v) begin
      r = max_v;
    end else if (r < min_v) begin
      r = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Two-stage signed complex multiplier (a * b) with rounding and saturation.
//   clk, rst         : clock, synchronous active-low reset
//   in_valid, in_sb  : input qualifier and sideband carried alongside the data
//   a_re, a_im       : A_W-bit signed data operand
//   b_re, b_im       : B_W-bit signed Q1.(B_W-1) coefficient
//   out_valid, out_sb: qualifier and sideband, 2 cycles after the input
//   out_re, out_im   : A_W-bit rounded, saturated product; held while invalid
module cmult_pipe
  import fft_pkg::*;
#(
  parameter int unsigned A_W  = DEF_DATA_W,
  parameter int unsigned B_W  = DEF_TW_W,
  parameter int unsigned SB_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [SB_W-1:0]       in_sb,
  input  logic signed [A_W-1:0] a_re,
  input  logic signed [A_W-1:0] a_im,
  input  logic signed [B_W-1:0] b_re,
  input  logic signed [B_W-1:0] b_im,
  output logic                  out_valid,
  output logic [SB_W-1:0]       out_sb,
  output logic signed [A_W-1:0] out_re,
  output logic signed [A_W-1:0] out_im
);

  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned S_W = P_W + 1;

  logic                  v2_d, v2_q;
  logic [SB_W-1:0]       sb2_d, sb2_q;
  logic signed [P_W-1:0] rr_d, rr_q, ii_d, ii_q, ri_d, ri_q, ir_d, ir_q;

  logic                  v3_d, v3_q;
  logic [SB_W-1:0]       sb3_d, sb3_q;
  logic signed [A_W-1:0] re3_d, re3_q, im3_d, im3_q;

  logic signed [S_W-1:0] re_sum, im_sum;

  always_comb begin
    v2_d  = in_valid;
    sb2_d = sb2_q;
    rr_d  = rr_q;
    ii_d  = ii_q;
    ri_d  = ri_q;
    ir_d  = ir_q;
    if (in_valid) begin
      sb2_d = in_sb;
      rr_d  = P_W'(a_re) * P_W'(b_re);
      ii_d  = P_W'(a_im) * P_W'(b_im);
      ri_d  = P_W'(a_re) * P_W'(b_im);
      ir_d  = P_W'(a_im) * P_W'(b_re);
    end

    re_sum = S_W'(rr_q) - S_W'(ii_q);
    im_sum = S_W'(ri_q) + S_W'(ir_q);

    v3_d  = v2_q;
    sb3_d = sb3_q;
    re3_d = re3_q;
    im3_d = im3_q;
    if (v2_q) begin
      sb3_d = sb2_q;
      re3_d = A_W'(sat_rnd(64'(re_sum), B_W - 1, A_W));
      im3_d = A_W'(sat_rnd(64'(im_sum), B_W - 1, A_W));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v2_q  <= 1'b0;
      sb2_q <= '0;
      rr_q  <= '0;
      ii_q  <= '0;
      ri_q  <= '0;
      ir_q  <= '0;
      v3_q  <= 1'b0;
      sb3_q <= '0;
      re3_q <= '0;
      im3_q <= '0;
    end else begin
      v2_q  <= v2_d;
      sb2_q <= sb2_d;
      rr_q  <= rr_d;
      ii_q  <= ii_d;
      ri_q  <= ri_d;
      ir_q  <= ir_d;
      v3_q  <= v3_d;
      sb3_q <= sb3_d;
      re3_q <= re3_d;
      im3_q <= im3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_sb    = sb3_q;
  assign out_re    = re3_q;
  assign out_im    = im3_q;

endmodule

// File: rtl/tw_cmult_st4.sv
// Stage-4 twiddle reader and multiplier.
// Tracks the sample index, drives the twiddle ROM address/read enable, delays
// each sample one cycle to meet the registered ROM output, and multiplies.
//   clk, rst              : clock, synchronous active-low reset
//   in_valid, in_sof      : input qualifier and frame start
//   in_re, in_im          : signed input sample
//   tw_addr, tw_valid     : ROM address and read enable (combinational)
//   tw_re, tw_im          : ROM output, valid one cycle after a read
//   out_valid/sof/last    : product qualifier, index-0 and index-(N-1) flags
//   out_re, out_im        : signed product, 3 cycles after the input
module tw_cmult_st4
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TW_W   = DEF_TW_W,
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic [ADDR_W-1:0]        tw_addr,
  output logic                     tw_valid,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic                     out_last,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  logic [ADDR_W-1:0]        idx_d, idx_q;
  logic [ADDR_W-1:0]        cur;

  logic                     s1_valid_d, s1_valid_q;
  logic                     s1_sof_d, s1_sof_q;
  logic                     s1_last_d, s1_last_q;
  logic signed [DATA_W-1:0] s1_re_d, s1_re_q;
  logic signed [DATA_W-1:0] s1_im_d, s1_im_q;

  logic [1:0]               out_sb;

  always_comb begin
    cur   = in_sof ? '0 : idx_q;
    idx_d = idx_q;
    if (in_valid) begin
      idx_d = (cur == LAST_IDX) ? '0 : cur + ADDR_W'(1);
    end

    s1_valid_d = in_valid;
    s1_sof_d   = s1_sof_q;
    s1_last_d  = s1_last_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    if (in_valid) begin
      // Frame start is index 0, so a wrap without in_sof still flags sof.
      s1_sof_d  = (cur == '0);
      s1_last_d = (cur == LAST_IDX);
      s1_re_d   = in_re;
      s1_im_d   = in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
    end else begin
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_sof_q   <= s1_sof_d;
      s1_last_q  <= s1_last_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
    end
  end

  assign tw_addr  = cur;
  assign tw_valid = in_valid & rst;

  cmult_pipe #(
    .A_W  (DATA_W),
    .B_W  (TW_W),
    .SB_W (2)
  ) u_cmult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_q),
    .in_sb     ({s1_sof_q, s1_last_q}),
    .a_re      (s1_re_q),
    .a_im      (s1_im_q),
    .b_re      (tw_re),
    .b_im      (tw_im),
    .out_valid (out_valid),
    .out_sb    (out_sb),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  assign out_sof  = out_sb[1];
  assign out_last = out_sb[0];

endmodule

// File: tb/tb_tw_cmult_st4.sv
// Directed bench for tw_cmult_st4 with a registered twiddle ROM model.
module tb_tw_cmult_st4;
  import fft_pkg::*;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_sof;
  logic signed [15:0] in_re, in_im;
  logic [3:0]         tw_addr;
  logic               tw_valid;
  logic signed [11:0] tw_re, tw_im;
  logic               out_valid, out_sof, out_last;
  logic signed [15:0] out_re, out_im;

  logic signed [11:0] rom_re [16];
  logic signed [11:0] rom_im [16];

  typedef struct {
    logic  v;
    logic  sof;
    logic  last;
    cplx_t d;
  } exp_t;

  exp_t  dl [2];
  cplx_t hold;
  int    n_cmp;
  int    n_err;

  tw_cmult_st4 #(.DATA_W(16), .TW_W(12), .N(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr), .tw_valid(tw_valid),
    .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid), .out_sof(out_sof),
    .out_last(out_last), .out_re(out_re), .out_im(out_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM holds its output when not read.
  always_ff @(posedge clk) begin
    if (tw_valid) begin
      tw_re <= rom_re[tw_addr];
      tw_im <= rom_im[tw_addr];
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 2; i++) begin
      dl[i].v = 1'b0; dl[i].sof = 1'b0; dl[i].last = 1'b0; dl[i].d = '0;
    end
  endtask

  // One cycle: apply inputs, check ROM drive, clock, check the output due now.
  task automatic cyc(input logic v, input logic sof, input int re, input int im,
                     input int ex_addr, input int o_re, input int o_im,
                     input logic o_sof, input logic o_last);
    exp_t e;
    exp_t r;
    in_valid = v;
    in_sof   = sof;
    in_re    = 16'(re);
    in_im    = 16'(im);
    #1;
    check("tw_valid", int'(tw_valid), int'(v));
    if (v) check("tw_addr", int'(tw_addr), ex_addr);
    @(posedge clk);
    #1;
    r.v = v; r.sof = o_sof; r.last = o_last;
    r.d.re = 16'(o_re); r.d.im = 16'(o_im);
    e = dl[1];
    dl[1] = dl[0];
    dl[0] = r;
    check("out_valid", int'(out_valid), int'(e.v));
    if (e.v) begin
      check("out_sof", int'(out_sof), int'(e.sof));
      check("out_last", int'(out_last), int'(e.last));
      check("out_re", int'(out_re), int'(e.d.re));
      check("out_im", int'(out_im), int'(e.d.im));
      hold = e.d;
    end else begin
      check("hold_re", int'(out_re), int'(hold.re));
      check("hold_im", int'(out_im), int'(hold.im));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_tw_valid", int'(tw_valid), 0);
      @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_re", int'(out_re), 0);
      check("rst_out_im", int'(out_im), 0);
    end
    rst = 1'b1;
    clear_pipe();
    hold = '0;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) begin
      rom_re[i] = '0;
      rom_im[i] = '0;
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    hold     = '0;
    clear_pipe();
    rom_clear();
    @(posedge clk);
    #1;

    // Reset with in_valid high, then first sample (no sof) reads address 0.
    do_reset(3);
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    idle(3);

    // Frame sweep with one unity twiddle at index 14, plus wrap to index 0.
    rom_re[14] = 12'sd2047;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i == 0, 1000, -500, i,
          (i == 14) ? 1000 : 0, (i == 14) ? -500 : 0, i == 0, i == 15);
    end
    cyc(1'b1, 1'b0, 1000, -500, 0, 0, 0, 1'b1, 1'b0);
    idle(3);

    // Saturation and rounding at full scale.
    rom_clear();
    rom_re[0] = 12'sd2047;  rom_im[0] = -12'sd2048;
    rom_re[1] = 12'sd2047;  rom_im[1] = 12'sd0;
    cyc(1'b1, 1'b1, -32768, -32768, 0, -32768, 16, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32767, 0, 1, 32751, 0, 1'b0, 1'b0);
    idle(3);

    // Bubbles: valid pattern 1,0,0,1,1; outputs hold in the gaps.
    rom_clear();
    rom_re[0] = 12'sd0;     rom_im[0] = 12'sd2047;
    rom_re[1] = 12'sd2047;  rom_im[1] = 12'sd0;
    rom_re[2] = -12'sd2048; rom_im[2] = 12'sd0;
    cyc(1'b1, 1'b1, 100, 200, 0, -200, 100, 1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 300, -400, 1, 300, -400, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 7, -9, 2, -7, 9, 1'b0, 1'b0);
    idle(3);

    // Resync: sof at index 9 restarts the frame.
    rom_clear();
    rom_re[0] = 12'sd2047;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, i == 0, 0, 0, i, 0, 0, i == 0, 1'b0);
    end
    cyc(1'b1, 1'b1, 10, 20, 0, 10, 20, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 1, 0, 0, 1'b0, 1'b0);
    idle(3);

    // Reset with two samples in flight; they must never emerge.
    cyc(1'b1, 1'b1, 10, 20, 0, 10, 20, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_re    = 16'sd10;
    in_im    = 16'sd20;
    @(posedge clk);
    #1;
    do_reset(1);
    cyc(1'b1, 1'b0, 10, 20, 0, 10, 20, 1'b1, 1'b0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
